// File: rtl/mem_bus_pkg.sv
// Shared definitions for word-organised memory bus blocks: FSM states, word size,
// error codes, and the access legality check.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int   WORD_BYTES = 4;
    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

    // The full 30-bit word address is compared, so high address bits can never alias into the array.
    function automatic logic access_err(input logic [31:0] addr, input int depth_log2);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return ((addr & 32'(WORD_BYTES - 1)) != 32'd0) || (word_idx >= (32'd1 << depth_log2));
    endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port 2^DEPTH_LOG2 x 32 word array: synchronous write, registered read, no reset.
// A read and write to the same word on one edge returns the old contents.
module word_ram #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a held response.
// Misaligned or out-of-range accesses answer with resp_err and leave memory untouched.
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        rdy_q;
    logic        load_ok;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] ram_rdata;

    logic        hs;
    logic        acc_now;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_err;

    assign hs = req_valid & req_ready;

    // With zero wait states the access happens on the acceptance edge itself, straight from the request bus.
    always_comb begin
        acc_now   = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_now   = hs && (WAIT_CYCLES == 0);
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else if (state == WAIT) begin
            acc_now = (cnt == 4'd0);
        end
        acc_err = access_err(acc_addr, DEPTH_LOG2);
    end

    word_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (acc_now & acc_we & ~acc_err & ~rst),
        .re    (acc_now & ~acc_we & ~acc_err & ~rst),
        .addr  (acc_addr[DEPTH_LOG2+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rdy_q      <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= ERR_NONE;
            load_ok    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdy_q   <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= acc_err ? ERR_ACCESS : ERR_NONE;
                            load_ok    <= ~acc_we & ~acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= acc_err ? ERR_ACCESS : ERR_NONE;
                        load_ok    <= ~acc_we & ~acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        rdy_q      <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= ERR_NONE;
                        load_ok    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready drops combinationally with rst so a request coinciding with reset is never accepted.
    assign req_ready  = rdy_q & ~rst;
    assign resp_rdata = load_ok ? ram_rdata : 32'd0;

endmodule
